zbc_clmul_seq: RTL

- Iterative carry-less multiply sequencer for Zbc. Executes clmul, clmulh and clmulr over several cycles, so the combinational XLEN×XLEN carry-less array is not needed in the BMU.
- Sits in the Execute stage beside the BMU and is launched by BMU decode for Zbc ops (funct3[1:0]).
- Requests a pipeline stall from the hazard unit while the operation runs.

---
 rtl/zbc_clmul_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/zbc_clmul_seq.sv
// Iterative carry-less multiplier for Zbc (clmul, clmulh, clmulr).
// Retires BITSPERCYCLE multiplier bits per cycle into a 2*XLEN accumulator.
module zbc_clmul_seq #(
  parameter int XLEN         = 64,
  parameter int BITSPERCYCLE = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic [1:0]      ZBCOpE,
  input  logic [XLEN-1:0] AE,
  input  logic [XLEN-1:0] BE,
  input  logic            StallE,
  input  logic            FlushE,
  output logic            ZBCBusyE,
  output logic            ZBCDoneE,
  output logic [XLEN-1:0] ZBCResultE
);

  localparam int N  = XLEN / BITSPERCYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT             state, nextState;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] aShift, acc, accNext;
  logic [XLEN-1:0]   bShift;
  logic [1:0]        op;
  logic [XLEN-1:0]   resultSel, result;
  logic              start, lastCycle;

  assign start     = StartE & ~FlushE;
  assign lastCycle = (count == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nextState = state;
    ZBCBusyE  = 1'b0;
    case (state)
      IDLE: begin
        ZBCBusyE = start;
        if (start) nextState = BUSY;
      end
      BUSY: begin
        ZBCBusyE = 1'b1;
        if (FlushE)         nextState = IDLE;
        else if (lastCycle) nextState = DONE;
      end
      DONE: begin
        if (FlushE || !StallE) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Multiplicand is pre-shifted so bit j of the slice always weights aShift << j.
  always_comb begin
    accNext = acc;
    for (int j = 0; j < BITSPERCYCLE; j++) begin
      if (bShift[j]) accNext = accNext ^ (aShift << j);
    end
  end

  // Last-cycle product is accNext, so the result register loads without an extra cycle.
  always_comb begin
    case (op)
      2'b11:   resultSel = accNext[2*XLEN-1:XLEN];
      2'b10:   resultSel = accNext[2*XLEN-2:XLEN-1];
      default: resultSel = accNext[XLEN-1:0];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      acc    <= '0;
      aShift <= '0;
      bShift <= '0;
      op     <= 2'b00;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          aShift <= {{XLEN{1'b0}}, AE};
          bShift <= BE;
          op     <= ZBCOpE;
          acc    <= '0;
          count  <= '0;
        end
        BUSY: begin
          acc    <= accNext;
          aShift <= aShift << BITSPERCYCLE;
          bShift <= bShift >> BITSPERCYCLE;
          count  <= count + CW'(1);
          if (lastCycle) result <= resultSel;
        end
        default: ;
      endcase
    end
  end

  assign ZBCDoneE   = (state == DONE);
  assign ZBCResultE = result;

endmodule
